// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: register index width, long-op FSM encoding and the
// shadow entry that tracks an in-flight destination register.
package hazard_scoreboard_pkg;
    localparam int REG_IDX_W = 5;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} long_state_e;

    typedef struct packed {
        logic                 v;
        logic [REG_IDX_W-1:0] rd;
        logic                 load;
        logic                 long_op;
    } shadow_t;
endpackage

// File: rtl/hazard_long_ctr.sv
// hazard_long_ctr: holds EX for the remaining LONG_LAT-1 cycles after a long op
// (MUL/DIV) enters it.
module hazard_long_ctr
    import hazard_scoreboard_pkg::*;
#(
    parameter int LONG_LAT = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start,
    output logic busy
);
    long_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            if (start) begin
                state_d = BUSY;
                cnt_d   = 4'(LONG_LAT - 1);
            end
        end else begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == BUSY);
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks EX/MEM destination registers and raises the stall,
// bubble, hold and flush controls for load-use hazards and long EX ops.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int LONG_LAT = 4,
    parameter int CNT_W    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ID_Valid_i,
    input  logic [REG_IDX_W-1:0] ID_Rs1_i,
    input  logic [REG_IDX_W-1:0] ID_Rs2_i,
    input  logic                 ID_UseRs1_i,
    input  logic                 ID_UseRs2_i,
    input  logic [REG_IDX_W-1:0] ID_Rd_i,
    input  logic                 ID_RegWrite_i,
    input  logic                 ID_MemRead_i,
    input  logic                 ID_Long_i,
    input  logic                 Branch_Taken_i,
    output logic                 PCWrite_o,
    output logic                 IF_ID_Write_o,
    output logic                 IF_Flush_o,
    output logic                 ID_EX_Bubble_o,
    output logic                 EX_Hold_o,
    output logic [CNT_W-1:0]     Stall_Cnt_o
);
    shadow_t          ex_q, ex_d, mem_q, mem_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             busy, load_use, stall, start;

    hazard_long_ctr #(.LONG_LAT(LONG_LAT)) u_long_ctr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .start (start),
        .busy  (busy)
    );

    always_comb begin
        load_use = ex_q.v & ex_q.load & ID_Valid_i &
                   ((ID_UseRs1_i & (ID_Rs1_i == ex_q.rd)) | (ID_UseRs2_i & (ID_Rs2_i == ex_q.rd)));
        stall          = busy | load_use;
        PCWrite_o      = ~stall;
        IF_ID_Write_o  = ~stall;
        ID_EX_Bubble_o = ~busy & load_use;
        EX_Hold_o      = busy;
        IF_Flush_o     = Branch_Taken_i & ~stall;
        // A held EX keeps its entry; the bubble it emits clears MEM.
        ex_d  = busy ? ex_q
              : (ID_Valid_i & ~ID_EX_Bubble_o)
                ? shadow_t'{ID_RegWrite_i & (ID_Rd_i != '0), ID_Rd_i, ID_MemRead_i, ID_Long_i}
                : '0;
        mem_d = busy ? '0 : ex_q;
        start = ~busy & ID_Valid_i & ~ID_EX_Bubble_o & ID_Long_i;
        stall_cnt_d = (stall & ~&stall_cnt_q) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ex_q        <= '0;
            mem_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign Stall_Cnt_o = stall_cnt_q;

    assert property (@(posedge clk_i) disable iff (!rst_i) busy |-> ex_q.long_op);
    assert property (@(posedge clk_i) disable iff (!rst_i) busy |=> (mem_q == '0));
endmodule
